// File: rtl/uP_pkg.sv
// Shared definitions for the program loader: frame constants, widths and FSM encoding.
// Latency: n/a (package).
// Backpressure: n/a (package).
package uP_pkg;

    localparam int          PROG_ADDR_W    = 12;
    localparam int          PROG_DATA_W    = 8;
    localparam logic [7:0]  PROG_SYNC_BYTE = 8'hA5;
    localparam int          PROG_TIMEOUT   = 1023;

    // Byte counter holds 1..256, so one bit wider than a byte.
    localparam int          LEN_CNT_W      = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_LEN    = 3'd3,
        ST_DATA   = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ABORT  = 3'd7
    } ld_state_t;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog for an in-flight frame; tc flags TIMEOUT idle cycles reached.
// Latency: tc is a combinational decode of the count register.
// Backpressure: none; count saturates at TIMEOUT until cleared.
module loader_timeout #(
    parameter int TIMEOUT = 1023
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    assign tc = (cnt == W'(TIMEOUT));

    // Count idle cycles while enabled; clear has priority, saturate at terminal count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Parses SYNC/ADDR/LEN/DATA/CSUM frames into program-memory writes, holding the CPU in reset meanwhile.
// Latency: one cycle from accepted data byte to mem_we pulse.
// Backpressure: in_ready drops only for the single DONE/ABORT cycle; otherwise every byte is taken.
module prog_loader
    import uP_pkg::*;
#(
    parameter int         ADDR_W    = PROG_ADDR_W,
    parameter int         DATA_W    = PROG_DATA_W,
    parameter logic [7:0] SYNC_BYTE = PROG_SYNC_BYTE,
    parameter int         TIMEOUT   = PROG_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // Bits of the address carried in the low nibble of the high header byte.
    localparam int HI_W = ADDR_W - 8;

    ld_state_t             state;
    logic [ADDR_W-1:0]     ptr;
    logic [LEN_CNT_W-1:0]  cnt;
    logic [7:0]            csum;
    logic [7:0]            csum_nxt;
    logic                  accept;
    logic                  in_frame;
    logic                  tmo_tc;

    assign accept   = in_valid && in_ready;
    assign csum_nxt = csum + in_data;
    assign in_frame = (state == ST_HDR_HI) || (state == ST_HDR_LO) || (state == ST_LEN) ||
                      (state == ST_DATA)   || (state == ST_CSUM);

    loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .clr   (accept || !in_frame),
        .en    (in_frame),
        .tc    (tmo_tc)
    );

    // Frame FSM with registered outputs; in_ready is pre-computed for the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            csum      <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mem_we   <= 1'b0;
            done     <= 1'b0;
            in_ready <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (accept && in_data == SYNC_BYTE) begin
                        state    <= ST_HDR_HI;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                ST_HDR_HI: begin
                    if (accept) begin
                        if (in_data[DATA_W-1:HI_W] != '0) begin
                            state    <= ST_ABORT;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            ptr[ADDR_W-1:8] <= in_data[HI_W-1:0];
                            state           <= ST_HDR_LO;
                        end
                    end else if (tmo_tc) begin
                        state    <= ST_ABORT;
                        error    <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                ST_HDR_LO: begin
                    if (accept) begin
                        ptr[7:0] <= in_data;
                        state    <= ST_LEN;
                    end else if (tmo_tc) begin
                        state    <= ST_ABORT;
                        error    <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        // A zero length field means a full 256-byte block.
                        cnt   <= (in_data == 8'h00) ? LEN_CNT_W'(256) : LEN_CNT_W'(in_data);
                        csum  <= 8'h00;
                        state <= ST_DATA;
                    end else if (tmo_tc) begin
                        state    <= ST_ABORT;
                        error    <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= in_data;
                        ptr       <= ptr + ADDR_W'(1);
                        csum      <= csum_nxt;
                        cnt       <= cnt - LEN_CNT_W'(1);
                        if (cnt == LEN_CNT_W'(1)) begin
                            state <= ST_CSUM;
                        end
                    end else if (tmo_tc) begin
                        state    <= ST_ABORT;
                        error    <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (csum_nxt == 8'h00) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ABORT;
                            error <= 1'b1;
                        end
                    end else if (tmo_tc) begin
                        state    <= ST_ABORT;
                        error    <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                ST_DONE, ST_ABORT: begin
                    state    <= ST_IDLE;
                    cpu_hold <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame-level reference model, random frames and gaps.
// Latency: n/a (testbench).
// Backpressure: driver waits on in_ready with a bounded loop.
module tb_prog_loader;
    import uP_pkg::*;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    prog_loader dut (
        .clock     (clock),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    int          ntests = 0;
    int          nfail  = 0;
    int          cyc    = 0;
    int          done_cnt = 0;
    int          hold_bad = 0;
    logic [19:0] wq[$];
    int          wcyc[$];
    logic [7:0]  tx_data[$];
    bit          err_model = 1'b0;

    // Cycle counter for back-to-back write checks.
    always @(posedge clock) cyc <= cyc + 1;

    // Observe memory writes, done pulses and cpu_hold consistency.
    always @(negedge clock) begin
        if (mem_we) begin
            wq.push_back({mem_addr, mem_wdata});
            wcyc.push_back(cyc);
        end
        if (done) done_cnt <= done_cnt + 1;
        if ((mem_we || done) && !cpu_hold) hold_bad <= hold_bad + 1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int g;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        g = 0;
        while (!in_ready && g < 50) begin
            @(negedge clock);
            g++;
        end
        if (g >= 50) chk_eq("rdy_wait", in_ready, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
    endtask

    // Send one frame built from tx_data and check it against the frame-level model.
    task automatic run_frame(input int base, input int len_field, input bit bad_csum,
                             input int maxgap, input bit b2b, input int stall);
        int         len, wbase, dbase, hbase, sum, nw;
        logic [7:0] cs;
        logic [11:0] a;
        len   = (len_field == 0) ? 256 : len_field;
        wbase = wq.size();
        dbase = done_cnt;
        hbase = hold_bad;
        send(PROG_SYNC_BYTE);
        chk_eq("sync_err_clr", error, 0);
        chk_eq("sync_hold", cpu_hold, 1);
        err_model = 1'b0;
        if (stall > 0) idle(stall);
        a = base[11:0];
        send({4'h0, a[11:8]});
        send(a[7:0]);
        send(len_field[7:0]);
        sum = 0;
        for (int i = 0; i < len; i++) begin
            send(tx_data[i]);
            sum += tx_data[i];
            if (maxgap > 0) idle($urandom_range(0, maxgap));
        end
        cs = 8'((256 - (sum % 256)) % 256);
        if (bad_csum) cs = cs + 8'h01;
        send(cs);
        idle(4);
        nw = wq.size() - wbase;
        chk_eq("nwrites", nw, len);
        for (int i = 0; i < len && i < nw; i++) begin
            a = 12'((base + i) % 4096);
            chk_eq("write", wq[wbase + i], {a, tx_data[i]});
            if (b2b) chk_eq("b2b", wcyc[wbase + i] - wcyc[wbase], i);
        end
        chk_eq("done_cnt", done_cnt - dbase, bad_csum ? 0 : 1);
        err_model = bad_csum;
        chk_eq("error", error, err_model);
        chk_eq("hold_end", cpu_hold, 0);
        chk_eq("hold_bad", hold_bad - hbase, 0);
    endtask

    task automatic fill(input int n);
        tx_data.delete();
        for (int i = 0; i < n; i++) tx_data.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int wbase, base, lf;
        bit bad;

        // Reset state.
        #12;
        chk_eq("rst_ready", in_ready, 0);
        chk_eq("rst_we", mem_we, 0);
        chk_eq("rst_hold", cpu_hold, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_err", error, 0);
        chk_eq("rst_addr", mem_addr, 0);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        chk_eq("ready_after_rst", in_ready, 1);

        // Basic good frame and the same frame with a bad checksum.
        tx_data = '{8'h11, 8'h22, 8'h33};
        run_frame(12'h010, 3, 1'b0, 0, 1'b1, 0);
        run_frame(12'h010, 3, 1'b1, 0, 1'b1, 0);
        idle(10);
        chk_eq("err_sticky", error, err_model);

        // Address wrap at the top of memory.
        tx_data = '{8'h01, 8'h02, 8'h03};
        run_frame(12'hFFE, 3, 1'b0, 0, 1'b1, 0);

        // Garbage in IDLE is dropped, then a 256-byte frame.
        wbase = wq.size();
        send(8'h00);
        send(8'h7E);
        idle(3);
        chk_eq("garbage_nw", wq.size() - wbase, 0);
        chk_eq("garbage_hold", cpu_hold, 0);
        fill(256);
        run_frame(12'h300, 0, 1'b0, 0, 1'b1, 0);

        // Bad header nibble aborts without writes.
        wbase = wq.size();
        send(PROG_SYNC_BYTE);
        send(8'h1F);
        idle(4);
        chk_eq("badhdr_err", error, 1);
        chk_eq("badhdr_nw", wq.size() - wbase, 0);
        chk_eq("badhdr_hold", cpu_hold, 0);

        // Stall inside a frame long enough to time out.
        wbase = wq.size();
        send(PROG_SYNC_BYTE);
        send(8'h00);
        idle(1100);
        chk_eq("tmo_err", error, 1);
        chk_eq("tmo_hold", cpu_hold, 0);
        chk_eq("tmo_nw", wq.size() - wbase, 0);
        chk_eq("tmo_ready", in_ready, 1);

        // A stall shorter than the timeout is tolerated.
        fill(4);
        run_frame(12'h123, 4, 1'b0, 1, 1'b0, 1000);

        // Reset asserted after the second data byte.
        fill(3);
        wbase = wq.size();
        send(PROG_SYNC_BYTE);
        send(8'h05);
        send(8'h50);
        send(8'h03);
        send(tx_data[0]);
        send(tx_data[1]);
        @(negedge clock);
        #2;
        in_data = tx_data[2];
        rst_n   = 1'b0;
        #1;
        chk_eq("arst_we", mem_we, 0);
        chk_eq("arst_hold", cpu_hold, 0);
        chk_eq("arst_err", error, 0);
        chk_eq("arst_ready", in_ready, 0);
        chk_eq("arst_addr", mem_addr, 0);
        chk_eq("arst_wdata", mem_wdata, 0);
        repeat (3) @(negedge clock);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        idle(3);
        chk_eq("arst_nw", wq.size() - wbase, 2);
        if (wq.size() - wbase >= 2) chk_eq("arst_w1", wq[wbase + 1], {12'h551, tx_data[1]});
        fill(5);
        run_frame(12'h700, 5, 1'b0, 0, 1'b1, 0);

        // Random frames with random gaps and occasional bad checksum.
        for (int k = 0; k < 10; k++) begin
            base = $urandom_range(0, 4095);
            lf   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 16);
            bad  = ($urandom_range(0, 3) == 0);
            fill(lf == 0 ? 256 : lf);
            run_frame(base, lf, bad, 2, 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
